// File: rtl/muldiv_unit_if.sv
// muldiv_unit_if: execute-stage <-> muldiv_unit handshake bundle
//   master (execute): drives valid, flush, op, is_word, a, b; samples ok, busy, result
//   slave  (unit)   : samples the operands, drives ok (one-cycle pulse), busy, result
interface muldiv_unit_if #(parameter int XLEN = 64);
  logic            valid;
  logic            flush;
  logic [2:0]      op;
  logic            is_word;
  logic [XLEN-1:0] a;
  logic [XLEN-1:0] b;
  logic            ok;
  logic            busy;
  logic [XLEN-1:0] result;
  modport master (output valid, flush, op, is_word, a, b, input ok, busy, result);
  modport slave (input valid, flush, op, is_word, a, b, output ok, busy, result);
endinterface

// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative radix-2 RV64M multiply/divide unit
//   clk, reset (async, active-high)
//   bus.slave: valid/flush/op/is_word/a/b in; ok (pulse), busy, result (registered) out
module muldiv_unit #(parameter int XLEN = 64) (
  input logic          clk,
  input logic          reset,
  muldiv_unit_if.slave bus
);
  localparam int H = XLEN / 2;
  localparam int CW = $clog2(XLEN + 1);
  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
  state_t            state_q;
  logic [2:0]        op_q;
  logic              word_q, sa_q, sb_q, ok_q;
  logic [CW-1:0]     count_q;
  logic [2*XLEN-1:0] acc_q, mc_q, acc_d, prod;
  logic [XLEN-1:0]   m_q, result_q, res_d, q_abs, r_abs;
  logic [XLEN:0]     trial;
  logic              is_div, word, sgn_a, sgn_b, sa, sb, div0, ovf;
  logic [XLEN-1:0]   aw, bw, mag_a, mag_b, min_v, spec_res;
  function automatic logic [XLEN-1:0] wext(input logic w, input logic [XLEN-1:0] v);
    return w ? {{H{v[H-1]}}, v[H-1:0]} : v;
  endfunction
  // word variants exist only for MUL and the divides; MULH*W is treated as 64-bit
  assign is_div   = bus.op[2];
  assign word     = bus.is_word & (is_div | (bus.op == 3'd0));
  assign sgn_a    = (bus.op == 3'd1) | (bus.op == 3'd2) | (is_div & !bus.op[0]);
  assign sgn_b    = (bus.op == 3'd1) | (is_div & !bus.op[0]);
  assign aw       = word ? {{H{sgn_a & bus.a[H-1]}}, bus.a[H-1:0]} : bus.a;
  assign bw       = word ? {{H{sgn_b & bus.b[H-1]}}, bus.b[H-1:0]} : bus.b;
  assign sa       = sgn_a & aw[XLEN-1];
  assign sb       = sgn_b & bw[XLEN-1];
  assign mag_a    = sa ? -aw : aw;
  assign mag_b    = sb ? -bw : bw;
  assign min_v    = word ? {{(H+1){1'b1}}, {(H-1){1'b0}}} : {1'b1, {(XLEN-1){1'b0}}};
  assign div0     = is_div & (bw == '0);
  assign ovf      = is_div & !bus.op[0] & (aw == min_v) & (bw == '1);
  assign spec_res = div0 ? (bus.op[1] ? aw : '1) : (bus.op[1] ? '0 : aw);
  // divide keeps {remainder, dividend/quotient} in acc_q; the shifted-in remainder needs XLEN+1 bits
  assign trial = acc_q[2*XLEN-1:XLEN-1] - {1'b0, m_q};
  assign acc_d = op_q[2] ? (trial[XLEN] ? {acc_q[2*XLEN-2:0], 1'b0}
                                        : {trial[XLEN-1:0], acc_q[XLEN-2:0], 1'b1})
                         : (m_q[0] ? acc_q + mc_q : acc_q);
  assign prod  = (sa_q ^ sb_q) ? -acc_d : acc_d;
  assign q_abs = acc_d[XLEN-1:0];
  assign r_abs = acc_d[2*XLEN-1:XLEN];
  assign res_d = wext(word_q, op_q[2] ? (op_q[1] ? (sa_q ? -r_abs : r_abs)
                                                 : ((sa_q ^ sb_q) ? -q_abs : q_abs))
                                      : ((op_q == 3'd0) ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN]));
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state_q  <= IDLE;
      ok_q     <= 1'b0;
      result_q <= '0;
      count_q  <= '0;
      acc_q    <= '0;
      mc_q     <= '0;
      m_q      <= '0;
      op_q     <= '0;
      word_q   <= 1'b0;
      sa_q     <= 1'b0;
      sb_q     <= 1'b0;
    end else if (state_q == IDLE) begin
      ok_q <= 1'b0;
      if (bus.valid && !bus.flush) begin
        op_q    <= bus.op;
        word_q  <= word;
        sa_q    <= sa;
        sb_q    <= sb;
        count_q <= word ? CW'(H) : CW'(XLEN);
        // word dividends sit in the upper half so quotient bits shift out MSB-first
        acc_q   <= is_div ? {{XLEN{1'b0}}, word ? {mag_a[H-1:0], {H{1'b0}}} : mag_a} : '0;
        mc_q    <= {{XLEN{1'b0}}, mag_a};
        m_q     <= mag_b;
        state_q <= (div0 || ovf) ? DONE : BUSY;
        ok_q    <= div0 || ovf;
        if (div0 || ovf) result_q <= wext(word, spec_res);
      end
    end else if (state_q == BUSY && !bus.flush) begin
      acc_q   <= acc_d;
      mc_q    <= mc_q << 1;
      m_q     <= op_q[2] ? m_q : m_q >> 1;
      count_q <= count_q - CW'(1);
      if (count_q == CW'(1)) begin
        state_q  <= DONE;
        ok_q     <= 1'b1;
        result_q <= res_d;
      end
    end else begin
      state_q <= IDLE;
      ok_q    <= 1'b0;
    end
  assign bus.ok     = ok_q;
  assign bus.busy   = state_q != IDLE;
  assign bus.result = result_q;
endmodule

// File: tb/tb_muldiv_unit.sv
// tb_muldiv_unit: randomized + directed bench for muldiv_unit against an arithmetic reference model
module tb_muldiv_unit;
  localparam logic [63:0] MIN64 = 64'h8000_0000_0000_0000;
  localparam logic [63:0] ONES  = 64'hFFFF_FFFF_FFFF_FFFF;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int n_cmp = 0;
  int n_fail = 0;
  always #5 clk = ~clk;
  muldiv_unit_if #(.XLEN(64)) bus();
  muldiv_unit #(.XLEN(64)) dut (.clk(clk), .reset(reset), .bus(bus));

  typedef struct {
    logic [2:0]  op;
    logic        w;
    logic [63:0] a;
    logic [63:0] b;
    logic [63:0] exp;
    int          lat;
  } vec_t;

  function automatic logic [63:0] sx32(input logic [63:0] v);
    return {{32{v[31]}}, v[31:0]};
  endfunction

  function automatic logic weff(input logic [2:0] op, input logic w);
    return w && (op == 3'd0 || op[2]);
  endfunction

  function automatic logic [63:0] wop(input logic [2:0] op, input logic w, input logic [63:0] v);
    if (!weff(op, w)) return v;
    return op[0] ? {32'h0, v[31:0]} : sx32(v);
  endfunction

  function automatic logic [63:0] model(input logic [2:0] op, input logic w, input logic [63:0] a, input logic [63:0] b);
    logic signed [127:0] pa, pb, p;
    logic [63:0] x, y, r;
    if (!op[2]) begin
      pa = (op == 3'd1 || op == 3'd2) ? {{64{a[63]}}, a} : {64'h0, a};
      pb = (op == 3'd1) ? {{64{b[63]}}, b} : {64'h0, b};
      p = pa * pb;
      if (op != 3'd0) return p[127:64];
      return weff(op, w) ? sx32(p[63:0]) : p[63:0];
    end
    x = wop(op, w, a);
    y = wop(op, w, b);
    if (y == 64'h0) r = op[1] ? x : ONES;
    else if (!op[0] && x == MIN64 && y == ONES) r = op[1] ? 64'h0 : MIN64;
    else if (!op[0]) r = op[1] ? $signed(x) % $signed(y) : $signed(x) / $signed(y);
    else r = op[1] ? x % y : x / y;
    return weff(op, w) ? sx32(r) : r;
  endfunction

  function automatic int exp_lat(input logic [2:0] op, input logic w, input logic [63:0] a, input logic [63:0] b);
    logic [63:0] x, y;
    if (op[2]) begin
      x = wop(op, w, a);
      y = wop(op, w, b);
      if (y == 64'h0) return 1;
      if (!op[0] && y == ONES && x == (weff(op, w) ? 64'hFFFF_FFFF_8000_0000 : MIN64)) return 1;
    end
    return weff(op, w) ? 33 : 65;
  endfunction

  function automatic logic [63:0] pick();
    case ($urandom_range(0, 7))
      0: return 64'h0;
      1: return ONES;
      2: return MIN64;
      3: return 64'hFFFF_FFFF_8000_0000;
      4: return 64'($urandom_range(0, 20));
      5: return {32'h0, $urandom};
      default: return {$urandom, $urandom};
    endcase
  endfunction

  task automatic run(input logic [2:0] op, input logic w, input logic [63:0] a, input logic [63:0] b,
                     output logic [63:0] res, output int lat, output int busy_n, output int extra_ok);
    @(posedge clk); #1;
    bus.op = op; bus.is_word = w; bus.a = a; bus.b = b; bus.valid = 1'b1;
    lat = -1; busy_n = 0; extra_ok = 0; res = 64'h0;
    for (int k = 1; k <= 100 && lat < 0; k++) begin
      @(posedge clk); #1;
      busy_n += int'(bus.busy);
      if (bus.ok) begin lat = k; res = bus.result; bus.valid = 1'b0; end
    end
    bus.valid = 1'b0;
    for (int k = 0; k < 2; k++) begin @(posedge clk); #1; extra_ok += int'(bus.ok); end
  endtask

  task automatic test_reset();
    repeat (3) @(posedge clk);
    #1;
    n_cmp++; if (bus.ok !== 1'b0) begin n_fail++; $display("FAIL reset_ok: got %b expected 0", bus.ok); end
    n_cmp++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b expected 0", bus.busy); end
    n_cmp++; if (bus.result !== 64'h0) begin n_fail++; $display("FAIL reset_result: got %h expected 0", bus.result); end
    reset = 1'b0;
  endtask

  task automatic test_mul_basic();
    logic [63:0] r; int lat, bn, eo;
    run(3'd0, 1'b0, 64'd3, 64'hFFFF_FFFF_FFFF_FFFB, r, lat, bn, eo);
    n_cmp++; if (r !== 64'hFFFF_FFFF_FFFF_FFF1) begin n_fail++; $display("FAIL mul_basic_result: got %h expected fffffffffffffff1", r); end
    n_cmp++; if (lat !== 65) begin n_fail++; $display("FAIL mul_basic_latency: got %0d expected 65", lat); end
    n_cmp++; if (bn !== 65) begin n_fail++; $display("FAIL mul_basic_busy_cycles: got %0d expected 65", bn); end
    n_cmp++; if (eo !== 0) begin n_fail++; $display("FAIL mul_basic_single_ok: got %0d extra ok expected 0", eo); end
  endtask

  task automatic test_directed();
    vec_t v[13];
    logic [63:0] r; int lat, bn, eo;
    v = '{
      '{3'd3, 1'b0, ONES, ONES, 64'hFFFF_FFFF_FFFF_FFFE, 65},
      '{3'd1, 1'b0, ONES, ONES, 64'h0, 65},
      '{3'd2, 1'b0, ONES, 64'd2, ONES, 65},
      '{3'd4, 1'b0, 64'd7, 64'd0, ONES, 1},
      '{3'd6, 1'b0, 64'd7, 64'd0, 64'd7, 1},
      '{3'd4, 1'b0, MIN64, ONES, MIN64, 1},
      '{3'd6, 1'b0, MIN64, ONES, 64'h0, 1},
      '{3'd4, 1'b1, 64'h1_8000_0000, ONES, 64'hFFFF_FFFF_8000_0000, 1},
      '{3'd7, 1'b1, 64'hFFFF_FFFF_FFFF_FFF9, 64'd5, 64'd4, 33},
      '{3'd4, 1'b0, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 64'hFFFF_FFFF_FFFF_FFFD, 65},
      '{3'd6, 1'b0, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, ONES, 65},
      '{3'd0, 1'b1, 64'h0000_0000_7FFF_FFFF, 64'd2, 64'hFFFF_FFFF_FFFF_FFFE, 33},
      '{3'd1, 1'b1, ONES, ONES, 64'h0, 65}
    };
    for (int i = 0; i < 13; i++) begin
      run(v[i].op, v[i].w, v[i].a, v[i].b, r, lat, bn, eo);
      n_cmp++; if (r !== v[i].exp) begin n_fail++; $display("FAIL directed_%0d_result: got %h expected %h", i, r, v[i].exp); end
      n_cmp++; if (lat !== v[i].lat) begin n_fail++; $display("FAIL directed_%0d_latency: got %0d expected %0d", i, lat, v[i].lat); end
      n_cmp++; if (eo !== 0) begin n_fail++; $display("FAIL directed_%0d_single_ok: got %0d extra ok expected 0", i, eo); end
    end
  endtask

  task automatic test_random();
    logic [63:0] r, a, b, e; logic [2:0] op; logic w; int lat, bn, eo, el;
    for (int i = 0; i < 50; i++) begin
      op = 3'($urandom_range(0, 7));
      w = 1'($urandom_range(0, 1));
      a = pick();
      b = pick();
      e = model(op, w, a, b);
      el = exp_lat(op, w, a, b);
      run(op, w, a, b, r, lat, bn, eo);
      n_cmp++; if (r !== e) begin n_fail++; $display("FAIL random_%0d_result op=%0d w=%b a=%h b=%h: got %h expected %h", i, op, w, a, b, r, e); end
      n_cmp++; if (lat !== el) begin n_fail++; $display("FAIL random_%0d_latency: got %0d expected %0d", i, lat, el); end
      n_cmp++; if (bn !== el) begin n_fail++; $display("FAIL random_%0d_busy_cycles: got %0d expected %0d", i, bn, el); end
      n_cmp++; if (eo !== 0) begin n_fail++; $display("FAIL random_%0d_single_ok: got %0d extra ok expected 0", i, eo); end
      n_cmp++; if (bus.result !== e) begin n_fail++; $display("FAIL random_%0d_result_hold: got %h expected %h", i, bus.result, e); end
    end
  endtask

  task automatic test_flush();
    logic [63:0] r; int lat, bn, eo, oks, busy11;
    run(3'd4, 1'b0, 64'd7, 64'd0, r, lat, bn, eo);
    @(posedge clk); #1;
    bus.op = 3'd5; bus.is_word = 1'b0; bus.a = 64'd1000; bus.b = 64'd3; bus.valid = 1'b1;
    oks = 0; busy11 = -1;
    for (int k = 1; k <= 11; k++) begin
      @(posedge clk); #1;
      oks += int'(bus.ok);
      if (k == 10) bus.flush = 1'b1;
      if (k == 11) begin busy11 = int'(bus.busy); bus.valid = 1'b0; bus.flush = 1'b0; end
    end
    n_cmp++; if (busy11 !== 0) begin n_fail++; $display("FAIL flush_busy_cycle11: got %0d expected 0", busy11); end
    n_cmp++; if (oks !== 0) begin n_fail++; $display("FAIL flush_no_ok: got %0d ok pulses expected 0", oks); end
    n_cmp++; if (bus.result !== ONES) begin n_fail++; $display("FAIL flush_result_kept: got %h expected %h", bus.result, ONES); end
    run(3'd0, 1'b0, 64'd6, 64'd7, r, lat, bn, eo);
    n_cmp++; if (r !== 64'd42) begin n_fail++; $display("FAIL flush_next_mul_result: got %h expected 2a", r); end
    n_cmp++; if (lat !== 65) begin n_fail++; $display("FAIL flush_next_mul_latency: got %0d expected 65 (cycle 77)", lat); end
    @(posedge clk); #1;
    bus.op = 3'd0; bus.a = 64'd3; bus.b = 64'd3; bus.valid = 1'b1; bus.flush = 1'b1;
    @(posedge clk); #1;
    bus.valid = 1'b0; bus.flush = 1'b0;
    n_cmp++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL flush_idle_no_capture: busy got %b expected 0", bus.busy); end
    repeat (3) @(posedge clk);
    #1;
    n_cmp++; if (bus.result !== 64'd42) begin n_fail++; $display("FAIL flush_idle_result_kept: got %h expected 2a", bus.result); end
  endtask

  task automatic test_async_reset();
    logic [63:0] r; int lat, bn, eo;
    @(posedge clk); #1;
    bus.op = 3'd5; bus.is_word = 1'b0; bus.a = {$urandom, $urandom}; bus.b = 64'd3; bus.valid = 1'b1;
    repeat (20) @(posedge clk);
    #3;
    reset = 1'b1;
    bus.valid = 1'b0;
    #1;
    n_cmp++; if (bus.ok !== 1'b0) begin n_fail++; $display("FAIL async_reset_ok: got %b expected 0", bus.ok); end
    n_cmp++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL async_reset_busy: got %b expected 0", bus.busy); end
    n_cmp++; if (bus.result !== 64'h0) begin n_fail++; $display("FAIL async_reset_result: got %h expected 0", bus.result); end
    @(posedge clk); #1;
    reset = 1'b0;
    run(3'd5, 1'b0, 64'd100, 64'd7, r, lat, bn, eo);
    n_cmp++; if (r !== 64'd14) begin n_fail++; $display("FAIL async_reset_divu_result: got %h expected e", r); end
    n_cmp++; if (lat !== 65) begin n_fail++; $display("FAIL async_reset_divu_latency: got %0d expected 65", lat); end
  endtask

  initial begin
    bus.valid = 1'b0; bus.flush = 1'b0; bus.op = 3'd0; bus.is_word = 1'b0; bus.a = 64'h0; bus.b = 64'h0;
    test_reset();
    test_mul_basic();
    test_directed();
    test_flush();
    test_async_reset();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
